fetch_unit: RTL and testbench

- Program-counter and fetch-register stage that drives the 6-bit address of the 64x9 instruction ROM and registers the combinational 9-bit word it returns.
- Presents a valid-tagged instruction to decode.
- Accepts stall and branch-redirect requests from downstream.
- Detects the halt word and reports completion via Start/Done.

---
 rtl/fetch_if.sv | 26 ++
 rtl/fetch_unit.sv | 87 ++++++++
 tb/tb_fetch_unit.sv | 135 +++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// Fetch stage bus bundle: control and redirect inputs, ROM address/data pair,
// and the instruction presented to decode.
interface fetch_if;
  logic       Start;
  logic       stall;
  logic       branch_taken;
  logic [5:0] branch_target;
  logic [8:0] rom_data;
  logic [5:0] pc;
  logic [8:0] ir;
  logic [5:0] ir_pc;
  logic       ir_valid;
  logic       Done;

  // Environment side: drives control, redirects and ROM data, observes fetch outputs.
  modport master (
    output Start, stall, branch_taken, branch_target, rom_data,
    input  pc, ir, ir_pc, ir_valid, Done
  );

  // Fetch unit side.
  modport slave (
    input  Start, stall, branch_taken, branch_target, rom_data,
    output pc, ir, ir_pc, ir_valid, Done
  );
endinterface

// File: rtl/fetch_unit.sv
// Program counter and fetch register for a 64x9 combinational instruction ROM.
// Runs from START_PC on Start, honours redirect > stall > fetch each cycle, and
// parks in HALT once the halt word has been fetched.
module fetch_unit #(
  parameter logic [5:0] START_PC  = 6'd0,
  parameter logic [8:0] HALT_WORD = 9'h1FF
) (
  input  logic   Clk,
  input  logic   Reset,
  fetch_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t     state_reg;
  logic [5:0] pc_reg;
  logic [8:0] ir_reg;
  logic [5:0] ir_pc_reg;
  logic       ir_valid_reg;
  logic       done_reg;

  assign bus.pc       = pc_reg;
  assign bus.ir       = ir_reg;
  assign bus.ir_pc    = ir_pc_reg;
  assign bus.ir_valid = ir_valid_reg;
  assign bus.Done     = done_reg;

  // Sequencer: state plus every registered output, updated together.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg    <= IDLE;
      pc_reg       <= 6'd0;
      ir_reg       <= 9'd0;
      ir_pc_reg    <= 6'd0;
      ir_valid_reg <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          ir_valid_reg <= 1'b0;
          if (bus.Start) begin
            state_reg <= RUN;
            pc_reg    <= START_PC;
          end
        end

        RUN: begin
          if (bus.branch_taken) begin
            // Wrong-path word is dropped; the ROM output this cycle is never looked at.
            pc_reg       <= bus.branch_target;
            ir_valid_reg <= 1'b0;
          end else if (!bus.stall) begin
            ir_reg       <= bus.rom_data;
            ir_pc_reg    <= pc_reg;
            ir_valid_reg <= 1'b1;
            if (bus.rom_data == HALT_WORD) begin
              // PC stays on the halt word's address.
              state_reg <= HALT;
              done_reg  <= 1'b1;
            end else begin
              pc_reg <= pc_reg + 6'd1;
            end
          end
        end

        HALT: begin
          if (bus.Start) begin
            state_reg    <= RUN;
            pc_reg       <= START_PC;
            done_reg     <= 1'b0;
            ir_valid_reg <= 1'b0;
          end else if (!bus.stall) begin
            // Halt word is delivered exactly once unless decode is stalled on it.
            ir_valid_reg <= 1'b0;
          end
        end

        default: begin
          state_reg    <= IDLE;
          ir_valid_reg <= 1'b0;
          done_reg     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a behavioural ROM driven from pc, a linear
// sequence of steps, and hand-computed expectations checked on the falling edge.
module tb_fetch_unit;
  logic Clk;
  logic Reset;
  logic [8:0] rom [64];
  int checks;
  int errors;

  fetch_if bus();

  fetch_unit #(.START_PC(6'd0), .HALT_WORD(9'h1FF)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  assign bus.rom_data = rom[bus.pc];

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // One clock: inputs were set at a falling edge, outputs are read at the next one.
  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [5:0] pc, input logic [8:0] ir,
                         input logic [5:0] ir_pc, input logic v, input logic done);
    chk({tag, ".pc"},       32'(bus.pc),       32'(pc));
    chk({tag, ".ir"},       32'(bus.ir),       32'(ir));
    chk({tag, ".ir_pc"},    32'(bus.ir_pc),    32'(ir_pc));
    chk({tag, ".ir_valid"}, 32'(bus.ir_valid), 32'(v));
    chk({tag, ".Done"},     32'(bus.Done),     32'(done));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 64; i++) rom[i] = 9'h000;
    rom[0]  = 9'h001;
    rom[1]  = 9'h002;
    rom[2]  = 9'h003;
    rom[3]  = 9'h1FF;
    rom[10] = 9'h0AA;
    rom[63] = 9'h005;

    Reset = 1'b1;
    bus.Start = 1'b0;
    bus.stall = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_target = 6'd0;
    @(negedge Clk);
    step();
    Reset = 1'b0;
    chk_out("reset", 6'd0, 9'h000, 6'd0, 1'b0, 1'b0);

    // Idle holds with no Start.
    step();
    chk_out("idle", 6'd0, 9'h000, 6'd0, 1'b0, 1'b0);

    // Start -> straight-line program to the halt word.
    bus.Start = 1'b1; step(); bus.Start = 1'b0;
    chk_out("start", 6'd0, 9'h000, 6'd0, 1'b0, 1'b0);
    step(); chk_out("f0", 6'd1, 9'h001, 6'd0, 1'b1, 1'b0);
    step(); chk_out("f1", 6'd2, 9'h002, 6'd1, 1'b1, 1'b0);
    step(); chk_out("f2", 6'd3, 9'h003, 6'd2, 1'b1, 1'b0);
    step(); chk_out("halt0", 6'd3, 9'h1FF, 6'd3, 1'b1, 1'b1);
    step(); chk_out("halt1", 6'd3, 9'h1FF, 6'd3, 1'b0, 1'b1);

    // Redirect is ignored while halted.
    bus.branch_taken = 1'b1; bus.branch_target = 6'd5;
    step(); bus.branch_taken = 1'b0;
    chk_out("halt_br", 6'd3, 9'h1FF, 6'd3, 1'b0, 1'b1);

    // Start in HALT restarts and clears Done.
    bus.Start = 1'b1; step(); bus.Start = 1'b0;
    chk_out("restart", 6'd0, 9'h1FF, 6'd3, 1'b0, 1'b0);
    step(); chk_out("r0", 6'd1, 9'h001, 6'd0, 1'b1, 1'b0);
    step(); chk_out("r1", 6'd2, 9'h002, 6'd1, 1'b1, 1'b0);

    // Three stall cycles with ir=002; Start mid-stall must be ignored.
    bus.stall = 1'b1;
    step(); chk_out("stall0", 6'd2, 9'h002, 6'd1, 1'b1, 1'b0);
    bus.Start = 1'b1;
    step(); chk_out("stall1", 6'd2, 9'h002, 6'd1, 1'b1, 1'b0);
    bus.Start = 1'b0;
    step(); chk_out("stall2", 6'd2, 9'h002, 6'd1, 1'b1, 1'b0);
    bus.stall = 1'b0;
    step(); chk_out("unstall", 6'd3, 9'h003, 6'd2, 1'b1, 1'b0);

    // Redirect with stall high while ROM shows the halt word: no halt, one bubble.
    bus.branch_taken = 1'b1; bus.branch_target = 6'd10; bus.stall = 1'b1;
    step();
    bus.branch_taken = 1'b0; bus.stall = 1'b0;
    chk_out("br10", 6'd10, 9'h003, 6'd2, 1'b0, 1'b0);
    step(); chk_out("tgt10", 6'd11, 9'h0AA, 6'd10, 1'b1, 1'b0);

    // Wrap from 63 to 0.
    bus.branch_taken = 1'b1; bus.branch_target = 6'd63;
    step(); bus.branch_taken = 1'b0;
    chk_out("br63", 6'd63, 9'h0AA, 6'd10, 1'b0, 1'b0);
    rom[0] = 9'h006;
    step(); chk_out("w63", 6'd0, 9'h005, 6'd63, 1'b1, 1'b0);
    step(); chk_out("w0", 6'd1, 9'h006, 6'd0, 1'b1, 1'b0);

    // Reset mid-run while stalled.
    bus.stall = 1'b1; Reset = 1'b1;
    step();
    Reset = 1'b0; bus.stall = 1'b0;
    chk_out("midrst", 6'd0, 9'h000, 6'd0, 1'b0, 1'b0);
    step(); chk_out("postrst", 6'd0, 9'h000, 6'd0, 1'b0, 1'b0);

    // Stall extends the single valid halt cycle.
    rom[0] = 9'h1FF;
    bus.Start = 1'b1; step(); bus.Start = 1'b0;
    step(); chk_out("h_now", 6'd0, 9'h1FF, 6'd0, 1'b1, 1'b1);
    bus.stall = 1'b1;
    step(); chk_out("h_stall", 6'd0, 9'h1FF, 6'd0, 1'b1, 1'b1);
    bus.stall = 1'b0;
    step(); chk_out("h_drop", 6'd0, 9'h1FF, 6'd0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
